sr_latch_driver: RTL and testbench
==================================

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter SETUP_CYC, default 2: cycles S/R are held stable with C=0 before the enable pulse; legal range 1..15.
REQ-002 Parameter PULSE_CYC, default 4: cycles C is high; legal range 1..15.
REQ-003 Parameter HOLD_CYC, default 1: cycles S/R are held with C=0 after the pulse; legal range 1..15.
REQ-004 Port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port RSTn, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port req, input, 1 bit: command valid.
REQ-007 Port op, input, 2 bits: 00 hold, 01 set, 10 reset, 11 toggle.
REQ-008 Port ready, output, 1 bit: block accepts a command this cycle.
REQ-009 Port C, output, 1 bit: latch enable to the downstream gated SR latch.
REQ-010 Port S, output, 1 bit: latch set, active-high.
REQ-011 Port R, output, 1 bit: latch reset, active-high.
REQ-012 Port Q, input, 1 bit: latch true output, asynchronous to CLK.
REQ-013 Port Qp, input, 1 bit: latch complement output, asynchronous to CLK.
REQ-014 Port done, output, 1 bit: one-cycle completion pulse.
REQ-015 Port err, output, 1 bit: one-cycle pulse with done when the latch readback mismatches.

Function
REQ-016 Q and Qp pass through a 2-flop synchronizer each; Qs/Qps denote the synchronized values.
REQ-017 A command is accepted when req=1 and ready=1 on a rising edge (cycle T); op is captured then and ignored afterwards.
REQ-018 The FSM states are IDLE, SETUP, PULSE, HOLD and CHECK; ready=1 only in IDLE.
REQ-019 Toggle resolves at acceptance from Qs: Qs=0 behaves as set, Qs=1 behaves as reset.
REQ-020 Expected value: set=1, reset=0, hold=Qs at T, toggle=~Qs at T.
REQ-021 SETUP drives the decoded S/R with C=0 for SETUP_CYC cycles, then goes to PULSE.
REQ-022 PULSE drives C=1 with S/R unchanged for PULSE_CYC cycles, then goes to HOLD.
REQ-023 HOLD drives C=0 with S/R unchanged for HOLD_CYC cycles, then goes to CHECK.
REQ-024 CHECK lasts 2 cycles with C=S=R=0 and compares in the second cycle: a mismatch is Qs!=expected or Qs==Qps.
REQ-025 On entering IDLE, done=1 and err=mismatch for exactly one cycle; ready=1 in that same cycle, and a new req is accepted then.
REQ-026 With defaults, accept at T gives SETUP T+1..T+2, PULSE T+3..T+6, HOLD T+7, CHECK T+8..T+9 and done at T+10.
REQ-027 S and R are never both 1; S/R change only while C=0; C=0 in every state except PULSE.
REQ-028 Op hold drives S=R=0 but still runs the full sequence including the C pulse.
REQ-029 req while ready=0 is ignored and not queued.
REQ-030 The phase counter is 4 bits, reloads on each state entry and never wraps.

Reset
REQ-031 RSTn=0 forces immediately and asynchronously: state=IDLE, C=S=R=0, done=0, err=0, counters=0 and synchronizer flops=0.
REQ-032 ready=1 from the first edge after RSTn deasserts.
REQ-033 Reset during any state aborts the command with no done pulse; the latch keeps its value.

Configuration
REQ-034 Macro SR_LATCH_DRIVER_CHECK_EN defined: CHECK state and readback behave per REQ-024/025.
REQ-035 Macro SR_LATCH_DRIVER_CHECK_EN undefined: CHECK is omitted, HOLD goes directly to IDLE, err is tied to 0, and done is at T+8 with defaults.

Verification
REQ-036 Reset, then op=01 at T with a behavioural latch model -> S=1 T+1..T+7, C=1 T+3..T+6, done=1 and err=0 at T+10, Q=1.
REQ-037 From Q=1, op=11 -> R=1 and S=0, done at T+10 with err=0, Q=0; repeat op=11 -> Q=1.
REQ-038 Model latch stuck at Q=Qp=0, op=01 -> done=1 and err=1 at T+10.
REQ-039 req held high for 20 cycles with op=10 -> accepts at T and T+10 only, and ready=0 T+1..T+9.
REQ-040 RSTn pulsed low at T+4 of a set -> C/S/R=0 immediately, no done, ready=1 on the next edge.
REQ-041 Build without SR_LATCH_DRIVER_CHECK_EN, op=01 -> done at T+8 and err constant 0.

Source files
------------

// File: rtl/sr_latch_driver_if.sv
// Command handshake bundle between a controller and sr_latch_driver.
// The master issues req/op and watches ready, done and err; the slave is the driver.
interface sr_latch_driver_if;
  logic       req;
  logic [1:0] op;
  logic       ready;
  logic       done;
  logic       err;

  modport master (output req, output op, input ready, input done, input err);
  modport slave  (input req, input op, output ready, output done, output err);
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: sequences S/R/C for a downstream gated SR latch.
// A command walks SETUP -> PULSE -> HOLD (-> CHECK) and ends with a one-cycle done pulse.
// Optional feature macro: SR_LATCH_DRIVER_CHECK_EN enables the CHECK readback state and err.
module sr_latch_driver #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 4,
  parameter int HOLD_CYC  = 1
) (
  input  logic                CLK,
  input  logic                RSTn,
  sr_latch_driver_if.slave    cmd,
  output logic                C,
  output logic                S,
  output logic                R,
  input  logic                Q,
  input  logic                Qp
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
  localparam logic [3:0] CHECK_LD = 4'd1;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       done_nxt;
  logic       run;
  logic       ready_int;
  logic       accept;
  logic       q_meta;
  logic       q_sync;
  logic       set_q;
  logic       rst_q;
  logic       drive;
  logic       done_q;

  assign accept = cmd.req & ready_int;

  // Two-flop synchronizer for the latch true output.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
    end else begin
      q_meta <= Q;
      q_sync <= q_meta;
    end
  end

  // Ready is withheld until the first clock edge after reset is released.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Decode the command at acceptance; toggle resolves from the synchronized latch value.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      set_q <= 1'b0;
      rst_q <= 1'b0;
    end else if (accept) begin
      case (cmd.op)
        2'b01:   begin set_q <= 1'b1;    rst_q <= 1'b0;   end
        2'b10:   begin set_q <= 1'b0;    rst_q <= 1'b1;   end
        2'b11:   begin set_q <= ~q_sync; rst_q <= q_sync; end
        default: begin set_q <= 1'b0;    rst_q <= 1'b0;   end
      endcase
    end
  end

  // State register and phase counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter reloads on every state entry and stops at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
`ifdef SR_LATCH_DRIVER_CHECK_EN
          state_nxt = CHECK;
          cnt_nxt   = CHECK_LD;
`else
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
`endif
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      CHECK: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
    done_nxt = (state != IDLE) && (state_nxt == IDLE);
  end

  // Outputs decoded from state: C only in PULSE, S/R held through SETUP..HOLD.
  always_comb begin
    ready_int = 1'b0;
    C         = 1'b0;
    drive     = 1'b0;
    S         = 1'b0;
    R         = 1'b0;
    ready_int = run && (state == IDLE);
    C         = (state == PULSE);
    drive     = (state == SETUP) || (state == PULSE) || (state == HOLD);
    S         = drive & set_q;
    R         = drive & rst_q;
  end

  // One-cycle done pulse on the cycle the FSM re-enters IDLE.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_nxt;
    end
  end

  assign cmd.ready = ready_int;
  assign cmd.done  = done_q;

`ifdef SR_LATCH_DRIVER_CHECK_EN
  logic qp_meta;
  logic qp_sync;
  logic exp_q;
  logic mismatch;
  logic err_q;

  // Two-flop synchronizer for the latch complement output.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      qp_meta <= 1'b0;
      qp_sync <= 1'b0;
    end else begin
      qp_meta <= Qp;
      qp_sync <= qp_meta;
    end
  end

  // Capture the value the latch should hold once the command completes.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      exp_q <= 1'b0;
    end else if (accept) begin
      case (cmd.op)
        2'b01:   exp_q <= 1'b1;
        2'b10:   exp_q <= 1'b0;
        2'b11:   exp_q <= ~q_sync;
        default: exp_q <= q_sync;
      endcase
    end
  end

  assign mismatch = (q_sync != exp_q) || (q_sync == qp_sync);

  // Error flag accompanies done when the final CHECK cycle sees a bad readback.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= done_nxt && (state == CHECK) && mismatch;
    end
  end

  assign cmd.err = err_q;
`else
  assign cmd.err = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver with a behavioural gated SR latch.
// Honors SR_LATCH_DRIVER_CHECK_EN the same way the design does.
module tb_sr_latch_driver;

  localparam int SC = 2;
  localparam int PC = 4;
  localparam int HC = 1;
`ifdef SR_LATCH_DRIVER_CHECK_EN
  localparam int CHK = 2;
`else
  localparam int CHK = 0;
`endif
  // Edges after acceptance until the done cycle is visible.
  localparam int LAT = SC + PC + HC + CHK;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic C, S, R, Q, Qp;
  logic lq = 1'b0;
  logic stuck = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [5:0] trace [0:LAT];

  sr_latch_driver_if cmd_bus ();

  sr_latch_driver #(.SETUP_CYC(SC), .PULSE_CYC(PC), .HOLD_CYC(HC)) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .cmd (cmd_bus),
    .C   (C),
    .S   (S),
    .R   (R),
    .Q   (Q),
    .Qp  (Qp)
  );

  always #5 CLK = ~CLK;

  // Behavioural gated SR latch, optionally stuck with both outputs low.
  always @(negedge CLK) begin
    if (C) begin
      if (S) lq <= 1'b1;
      else if (R) lq <= 1'b0;
    end
  end
  assign Q  = stuck ? 1'b0 : lq;
  assign Qp = stuck ? 1'b0 : ~lq;

  // Expected {C,S,R,ready,done,err} k edges after acceptance.
  function automatic logic [5:0] exp_vec(input logic [1:0] op_v, input logic lseen,
                                         input logic stk, input int k);
    logic es, er, drv, c, last;
    es   = (op_v == 2'b01) || (op_v == 2'b11 && lseen == 1'b0);
    er   = (op_v == 2'b10) || (op_v == 2'b11 && lseen == 1'b1);
    drv  = k < SC + PC + HC;
    c    = (k >= SC) && (k < SC + PC);
    last = (k == LAT);
    return {c, es & drv, er & drv, last, last, last & (CHK != 0) & stk};
  endfunction

  // Latch value the command should leave behind.
  function automatic logic exp_final(input logic [1:0] op_v, input logic lseen);
    case (op_v)
      2'b01:   return 1'b1;
      2'b10:   return 1'b0;
      2'b11:   return ~lseen;
      default: return lseen;
    endcase
  endfunction

  // Issue one command from a negedge and record outputs for LAT+1 cycles.
  task automatic run_cmd(input logic [1:0] op_v, output logic lseen);
    int w;
    w = 0;
    while (!cmd_bus.ready && w < 40) begin
      @(negedge CLK);
      w++;
    end
    if (!cmd_bus.ready) begin
      n_fail++;
      $display("[TB] FAIL ready_wait: ready=%b required 1", cmd_bus.ready);
    end
    lseen = stuck ? 1'b0 : lq;
    cmd_bus.req = 1'b1;
    cmd_bus.op  = op_v;
    @(posedge CLK);
    #1;
    cmd_bus.req = 1'b0;
    cmd_bus.op  = 2'($urandom_range(0, 3));
    for (int k = 0; k <= LAT; k++) begin
      @(negedge CLK);
      trace[k] = {C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err};
    end
  endtask

  task automatic test_reset();
    cmd_bus.req = 1'b0;
    cmd_bus.op  = 2'b00;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err} !== 6'b000000) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: CSR/rdy/done/err=%b required 000000",
               {C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err});
    end
    RSTn = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err} !== 6'b000100) begin
      n_fail++;
      $display("[TB] FAIL reset_release: CSR/rdy/done/err=%b required 000100",
               {C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err});
    end
  endtask

  task automatic test_set();
    logic ls;
    run_cmd(2'b01, ls);
    for (int k = 0; k <= LAT; k++) begin
      n_checks++;
      if (trace[k] !== exp_vec(2'b01, ls, 1'b0, k)) begin
        n_fail++;
        $display("[TB] FAIL set_cycle%0d: got %b required %b", k, trace[k], exp_vec(2'b01, ls, 1'b0, k));
      end
    end
    n_checks++;
    if (lq !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL set_latch: Q=%b required 1", lq);
    end
  endtask

  task automatic test_toggle();
    logic ls, fin;
    for (int n = 0; n < 2; n++) begin
      run_cmd(2'b11, ls);
      fin = exp_final(2'b11, ls);
      for (int k = 0; k <= LAT; k++) begin
        n_checks++;
        if (trace[k] !== exp_vec(2'b11, ls, 1'b0, k)) begin
          n_fail++;
          $display("[TB] FAIL toggle%0d_cycle%0d: got %b required %b", n, k, trace[k], exp_vec(2'b11, ls, 1'b0, k));
        end
      end
      n_checks++;
      if (lq !== fin) begin
        n_fail++;
        $display("[TB] FAIL toggle%0d_latch: Q=%b required %b", n, lq, fin);
      end
    end
  endtask

  task automatic test_stuck();
    logic ls;
    stuck = 1'b1;
    repeat (3) @(negedge CLK);
    run_cmd(2'b01, ls);
    for (int k = 0; k <= LAT; k++) begin
      n_checks++;
      if (trace[k] !== exp_vec(2'b01, ls, 1'b1, k)) begin
        n_fail++;
        $display("[TB] FAIL stuck_cycle%0d: got %b required %b", k, trace[k], exp_vec(2'b01, ls, 1'b1, k));
      end
    end
    stuck = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    int w;
    cmd_bus.req = 1'b1;
    cmd_bus.op  = 2'b10;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK);
      if (k == 19) begin
        #1;
        cmd_bus.req = 1'b0;
      end
      @(negedge CLK);
      exp_rdy = ((k + 1) % (LAT + 1)) == 0;
      n_checks++;
      if ({cmd_bus.ready, cmd_bus.done} !== {exp_rdy, exp_rdy}) begin
        n_fail++;
        $display("[TB] FAIL b2b_cycle%0d: ready/done=%b required %b", k,
                 {cmd_bus.ready, cmd_bus.done}, {exp_rdy, exp_rdy});
      end
    end
    w = 0;
    while (!cmd_bus.ready && w < 40) begin
      @(negedge CLK);
      w++;
    end
    n_checks++;
    if ({cmd_bus.ready, lq} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL b2b_final: ready/Q=%b required 10", {cmd_bus.ready, lq});
    end
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    cmd_bus.req = 1'b1;
    cmd_bus.op  = 2'b01;
    @(posedge CLK);
    #1;
    cmd_bus.req = 1'b0;
    repeat (4) @(negedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    n_checks++;
    if ({C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err} !== 6'b000000) begin
      n_fail++;
      $display("[TB] FAIL abort_async: CSR/rdy/done/err=%b required 000000",
               {C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err});
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err} !== 6'b000100) begin
      n_fail++;
      $display("[TB] FAIL abort_release: CSR/rdy/done/err=%b required 000100",
               {C, S, R, cmd_bus.ready, cmd_bus.done, cmd_bus.err});
    end
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      saw_done = saw_done | cmd_bus.done;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_no_done: done seen=%b required 0", saw_done);
    end
  endtask

  task automatic test_random();
    logic [1:0] op_v;
    logic ls, fin;
    for (int n = 0; n < 20; n++) begin
      op_v = 2'($urandom_range(0, 3));
      run_cmd(op_v, ls);
      fin = exp_final(op_v, ls);
      for (int k = 0; k <= LAT; k++) begin
        n_checks++;
        if (trace[k] !== exp_vec(op_v, ls, 1'b0, k)) begin
          n_fail++;
          $display("[TB] FAIL rand%0d_op%0d_cycle%0d: got %b required %b", n, op_v, k, trace[k],
                   exp_vec(op_v, ls, 1'b0, k));
        end
      end
      n_checks++;
      if (lq !== fin) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_latch: Q=%b required %b", n, lq, fin);
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  initial begin
    cmd_bus.req = 1'b0;
    cmd_bus.op  = 2'b00;
    test_reset();
    test_set();
    test_toggle();
    test_stuck();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
